hazard_ctrl: RTL and testbench

//   Pipeline sequencing controller for the 5-stage core. Decides each cycle

---
 rtl/hazard_if.sv | 19 +
 rtl/hazard_ctrl.sv | 67 ++++++
 tb/tb_hazard_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/hazard_if.sv
// hazard_if: ID/EX/MEM hazard status in, pipeline sequencing controls out.
interface hazard_if #(parameter int REGADDR_WIDTH = 4, parameter int CNT_WIDTH = 16);
    logic [REGADDR_WIDTH-1:0] id_rs, id_rt, ex_rd;
    logic id_uses_rs, id_uses_rt, id_halt, ex_mem_read, ex_branch_taken, mem_req, mem_ready;
    logic pc_write, pc_sel, if_id_write, if_id_flush, id_ex_flush, pipe_freeze, halted, timeout_err;
    logic [CNT_WIDTH-1:0] stall_cnt, flush_cnt;
    modport master (
        output id_rs, id_rt, ex_rd, id_uses_rs, id_uses_rt, id_halt, ex_mem_read,
               ex_branch_taken, mem_req, mem_ready,
        input  pc_write, pc_sel, if_id_write, if_id_flush, id_ex_flush, pipe_freeze,
               halted, timeout_err, stall_cnt, flush_cnt
    );
    modport slave (
        input  id_rs, id_rt, ex_rd, id_uses_rs, id_uses_rt, id_halt, ex_mem_read,
               ex_branch_taken, mem_req, mem_ready,
        output pc_write, pc_sel, if_id_write, if_id_flush, id_ex_flush, pipe_freeze,
               halted, timeout_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: 5-stage pipeline sequencing for load-use, branch squash, dmem waits and HALT drain.
module hazard_ctrl #(
    parameter int CNT_WIDTH    = 16,
    parameter int DRAIN_CYCLES = 3,
    parameter int MEM_TIMEOUT  = 255
) (
    input logic clk,
    input logic reset,
    hazard_if.slave h
);
    localparam int TW = $clog2(MEM_TIMEOUT + 1);
    localparam int DW = $clog2(DRAIN_CYCLES + 2);
    typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALTED} state_t;
    state_t state;
    logic [TW-1:0] tmr;
    logic [DW-1:0] dcnt;
    logic wait_c, load_use, active, br, lu, hl, frz;
    always_comb begin
        wait_c   = h.mem_req & ~h.mem_ready;
        load_use = h.ex_mem_read & ((h.id_uses_rs & (h.id_rs == h.ex_rd)) |
                                    (h.id_uses_rt & (h.id_rt == h.ex_rd)));
        active   = (state == RUN) | (state == MEM_WAIT);
        br       = active & ~wait_c & h.ex_branch_taken;
        lu       = active & ~wait_c & ~br & load_use;
        hl       = active & ~wait_c & ~br & ~lu & h.id_halt;
        frz      = ~reset & (state != HALTED) & wait_c;
        h.pc_write    = ~reset & active & ~wait_c & ~lu & ~hl;
        h.if_id_write = h.pc_write;
        h.pc_sel      = ~reset & br;
        h.if_id_flush = reset | br | (state == HALTED);
        h.id_ex_flush = reset | br | lu | hl | ((state == DRAIN) & ~wait_c) | (state == HALTED);
        h.pipe_freeze = frz;
    end
    // A frozen cycle in DRAIN pauses the drain counter; the wait timer only counts consecutive freezes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= RUN;
            tmr           <= '0;
            dcnt          <= '0;
            h.halted      <= 1'b0;
            h.timeout_err <= 1'b0;
            h.stall_cnt   <= '0;
            h.flush_cnt   <= '0;
        end else if (frz) begin
            tmr <= tmr + 1'b1;
            if (~&h.stall_cnt) h.stall_cnt <= h.stall_cnt + 1'b1;
            if (tmr == TW'(MEM_TIMEOUT - 1)) begin
                h.timeout_err <= 1'b1;
                h.halted      <= 1'b1;
                state         <= HALTED;
            end else if (state == RUN) state <= MEM_WAIT;
        end else begin
            tmr <= '0;
            if (active) begin
                state <= hl ? DRAIN : RUN;
                if (hl) dcnt <= DW'(DRAIN_CYCLES);
                if (br && ~&h.flush_cnt) h.flush_cnt <= h.flush_cnt + 1'b1;
                if (lu && ~&h.stall_cnt) h.stall_cnt <= h.stall_cnt + 1'b1;
            end else if (state == DRAIN) begin
                if (dcnt <= DW'(1)) begin
                    state    <= HALTED;
                    h.halted <= 1'b1;
                end else dcnt <= dcnt - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors with hand-computed expectations for hazard_ctrl.
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_vec = 0;
    int n_err = 0;
    hazard_if #(.REGADDR_WIDTH(4), .CNT_WIDTH(16)) hif ();
    hazard_ctrl #(.CNT_WIDTH(16), .DRAIN_CYCLES(3), .MEM_TIMEOUT(255)) dut (
        .clk(clk), .reset(reset), .h(hif.slave)
    );
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        hif.id_rs = '0; hif.id_rt = '0; hif.ex_rd = '0;
        hif.id_uses_rs = 0; hif.id_uses_rt = 0; hif.id_halt = 0; hif.ex_mem_read = 0;
        hif.ex_branch_taken = 0; hif.mem_req = 0; hif.mem_ready = 0;
    endtask

    initial begin
        clr();
        cyc(); cyc();
        chk("rst_pc_write", hif.pc_write, 0);
        chk("rst_if_flush", hif.if_id_flush, 1);
        chk("rst_ex_flush", hif.id_ex_flush, 1);
        chk("rst_freeze", hif.pipe_freeze, 0);
        chk("rst_halted", hif.halted, 0);
        chk("rst_stall", hif.stall_cnt, 0);
        reset = 0;
        #1;
        chk("run_pc_write", hif.pc_write, 1);
        chk("run_ex_flush", hif.id_ex_flush, 0);
        // T2: matching register but not read
        hif.ex_mem_read = 1; hif.ex_rd = 3; hif.id_rs = 3; hif.id_uses_rs = 0;
        #1;
        chk("t2_pc_write", hif.pc_write, 1);
        chk("t2_ex_flush", hif.id_ex_flush, 0);
        cyc();
        // T1: true load-use on rs
        hif.id_uses_rs = 1;
        #1;
        chk("t1_pc_write", hif.pc_write, 0);
        chk("t1_if_write", hif.if_id_write, 0);
        chk("t1_ex_flush", hif.id_ex_flush, 1);
        cyc();
        hif.ex_mem_read = 0;
        #1;
        chk("t1_resume", hif.pc_write, 1);
        chk("t1_stall_cnt", hif.stall_cnt, 1);
        // load-use on rt with register 0
        clr(); hif.ex_mem_read = 1; hif.id_uses_rt = 1;
        #1;
        chk("r0_pc_write", hif.pc_write, 0);
        cyc(); clr();
        #1;
        chk("r0_stall_cnt", hif.stall_cnt, 2);
        // T3: branch squashes concurrent load-use
        hif.ex_mem_read = 1; hif.ex_rd = 5; hif.id_rs = 5; hif.id_uses_rs = 1; hif.ex_branch_taken = 1;
        #1;
        chk("t3_pc_sel", hif.pc_sel, 1);
        chk("t3_pc_write", hif.pc_write, 1);
        chk("t3_if_flush", hif.if_id_flush, 1);
        chk("t3_ex_flush", hif.id_ex_flush, 1);
        cyc(); clr();
        #1;
        chk("t3_flush_cnt", hif.flush_cnt, 1);
        chk("t3_stall_cnt", hif.stall_cnt, 2);
        // T4: four frozen cycles, branch held off while frozen
        hif.mem_req = 1; hif.ex_branch_taken = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t4_freeze", hif.pipe_freeze, 1);
            chk("t4_pc_write", hif.pc_write, 0);
            chk("t4_pc_sel", hif.pc_sel, 0);
            cyc();
        end
        hif.ex_branch_taken = 0; hif.mem_ready = 1;
        #1;
        chk("t4_unfreeze", hif.pipe_freeze, 0);
        chk("t4_pc_write", hif.pc_write, 1);
        chk("t4_stall_cnt", hif.stall_cnt, 6);
        chk("t4_flush_cnt", hif.flush_cnt, 1);
        cyc(); clr();
        // T5: halt drains in 1 + 3 cycles
        hif.id_halt = 1;
        #1;
        chk("t5_ex_flush", hif.id_ex_flush, 1);
        chk("t5_pc_write", hif.pc_write, 0);
        cyc(); clr();
        for (int i = 1; i < 4; i++) begin
            chk("t5_not_halted", hif.halted, 0);
            chk("t5_drain_pc", hif.pc_write, 0);
            cyc();
        end
        chk("t5_halted", hif.halted, 1);
        chk("t5_h_if_flush", hif.if_id_flush, 1);
        chk("t5_h_pc_write", hif.pc_write, 0);
        reset = 1;
        #1;
        chk("t5_async_halted", hif.halted, 0);
        chk("t5_async_stall", hif.stall_cnt, 0);
        cyc(); reset = 0;
        // T5b: two frozen cycles inside DRAIN stretch it to 6
        hif.id_halt = 1;
        cyc(); clr();
        hif.mem_req = 1;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("t5b_freeze", hif.pipe_freeze, 1);
            cyc();
        end
        clr();
        for (int i = 3; i < 6; i++) begin
            chk("t5b_not_halted", hif.halted, 0);
            cyc();
        end
        chk("t5b_halted", hif.halted, 1);
        chk("t5b_stall_cnt", hif.stall_cnt, 2);
        reset = 1; cyc(); reset = 0;
        // reset mid-DRAIN returns to RUN
        hif.id_halt = 1;
        cyc(); clr();
        #1;
        chk("md_drain_pc", hif.pc_write, 0);
        reset = 1; cyc(); reset = 0;
        #1;
        chk("md_run_pc", hif.pc_write, 1);
        // T6: memory timeout
        hif.mem_req = 1;
        for (int i = 0; i < 254; i++) cyc();
        chk("t6_no_timeout", hif.timeout_err, 0);
        cyc();
        chk("t6_timeout", hif.timeout_err, 1);
        chk("t6_halted", hif.halted, 1);
        chk("t6_stall_cnt", hif.stall_cnt, 255);
        chk("t6_no_freeze", hif.pipe_freeze, 0);
        clr();
        reset = 1;
        #1;
        chk("t6_rst_timeout", hif.timeout_err, 0);
        chk("t6_rst_halted", hif.halted, 0);
        cyc(); reset = 0;
        #1;
        chk("t6_run_pc", hif.pc_write, 1);
        chk("t6_run_flush", hif.id_ex_flush, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
